// File: rtl/cube_line_sequencer.sv
// Frame sequencer for the cube wireframe: walks a small segment table once per
// frame and feeds each segment to the Bresenham engine, with a per-segment watchdog.
module cube_line_sequencer #(
    parameter int NSEG    = 16,
    parameter int TIMEOUT = 2000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(NSEG)-1:0] wr_addr,
    input  logic [10:0]             wr_x0,
    input  logic [9:0]              wr_y0,
    input  logic [10:0]             wr_x1,
    input  logic [9:0]              wr_y1,
    input  logic [$clog2(NSEG):0]   num_seg,
    input  logic                    frame_start,
    input  logic                    eng_done,
    output logic                    eng_start,
    output logic [10:0]             eng_x0,
    output logic [9:0]              eng_y0,
    output logic [10:0]             eng_x1,
    output logic [9:0]              eng_y1,
    output logic [$clog2(NSEG)-1:0] seg_idx,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun,
    output logic                    timeout_err
);
    localparam int AW = $clog2(NSEG);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(NSEG);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef struct packed {
        logic [10:0] x0;
        logic [9:0]  y0;
        logic [10:0] x1;
        logic [9:0]  y1;
    } seg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_e;

    seg_t          table_q [NSEG];
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [WW-1:0] wd_q, wd_d;
    seg_t          eng_q, eng_d;
    logic          busy_q, busy_d;
    logic          start_q, start_d;
    logic          fdone_q, fdone_d;
    logic          ovr_q, ovr_d;
    logic          tmo_q, tmo_d;

    // NOTE: the table is a plain register array, so it is cleared by reset
    // like every other flop; a RAM macro could not be reset this way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSEG; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[wr_addr] <= {wr_x0, wr_y0, wr_x1, wr_y1};
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        eng_d   = eng_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        fdone_d = 1'b0;
        ovr_d   = ovr_q;
        tmo_d   = tmo_q;

        // Any start request outside IDLE (including the FINISH cycle) is dropped.
        if (frame_start && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    cnt_d   = (num_seg > CNT_MAX) ? CNT_MAX : num_seg;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (num_seg == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_d   = table_q[idx_q];
                start_d = 1'b1;
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    state_d = S_NEXT;
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_NEXT: begin
                if ({1'b0, idx_q} == cnt_q - CW'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                fdone_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
            eng_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            fdone_q <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            eng_q   <= eng_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            fdone_q <= fdone_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign eng_start   = start_q;
    assign eng_x0      = eng_q.x0;
    assign eng_y0      = eng_q.y0;
    assign eng_x1      = eng_q.x1;
    assign eng_y1      = eng_q.y1;
    assign seg_idx     = idx_q;
    assign busy        = busy_q;
    assign frame_done  = fdone_q;
    assign overrun     = ovr_q;
    assign timeout_err = tmo_q;

endmodule
